rf_wb_sched: RTL and testbench

//  Shares the register file's single write port among N writeback requesters (ALU, load unit, mul/div).

---
 rtl/rf_wb_sched_pkg.sv | 20 ++
 rtl/rf_wb_sched_arb.sv | 53 +++++
 rtl/rf_wb_sched.sv | 141 ++++++++++++++
 tb/tb_rf_wb_sched.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_sched_pkg.sv
// Shared constants for the register-file writeback scheduler: default widths,
// requester count and the fixed requester index encoding.
package rf_wb_sched_pkg;

   localparam int RF_XLEN    = 32;   // data width
   localparam int RF_AW      = 5;    // register address width
   localparam int RF_WB_NREQ = 3;    // default number of writeback requesters

   // Requester index encoding (slice index into req_* vectors)
   localparam int WB_ALU = 0;
   localparam int WB_LSU = 1;
   localparam int WB_MDU = 2;

   typedef enum logic [1:0] {
      WB_SRC_ALU = 2'd0,
      WB_SRC_LSU = 2'd1,
      WB_SRC_MDU = 2'd2
   } wb_src_e;

endpackage

// File: rtl/rf_wb_sched_arb.sv
// Reusable round-robin arbiter: pointer register plus rotate/priority-encode.
// The search starts at the pointer and wraps; a grant to i moves the pointer
// to i+1 (mod N). Grants are forced to zero while rst is high.
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_r;
   logic [PW-1:0] ptr_nxt_s;
   logic [N-1:0]  grant_s;

   // Pick the valid requester with the smallest rotated distance from the pointer
   always_comb begin
      int d;
      int best_d;
      grant_s   = '0;
      ptr_nxt_s = ptr_r;
      best_d    = N;
      d         = 0;
      for (int i = 0; i < N; i++) begin
         d = (i >= int'(ptr_r)) ? (i - int'(ptr_r)) : (i - int'(ptr_r) + N);
         if (req[i] && (d < best_d)) begin
            best_d     = d;
            grant_s    = '0;
            grant_s[i] = 1'b1;
            ptr_nxt_s  = PW'((i + 1) % N);
         end else begin
            best_d = best_d;
         end
      end
   end

   assign grant = grant_s & {N{~rst}};

   // Advance the pointer past the winner; hold it when nobody requested
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_r <= '0;
      end else if (|grant_s) begin
         ptr_r <= ptr_nxt_s;
      end else begin
         ptr_r <= ptr_r;
      end
   end

endmodule

// File: rtl/rf_wb_sched.sv
// Register-file writeback scheduler: shares the single reg_file write port
// among N_REQ requesters through a round-robin arbiter and a one-stage
// registered write pipe, and keeps a pending-destination scoreboard so decode
// can stall on RAW hazards against multi-cycle ops.
// Optional feature macro: RF_WB_BYPASS_EN adds byp1/byp2 forwarding ports from
// the write pipe and removes the write-pipe term from the stall equation.
module rf_wb_sched
   import rf_wb_sched_pkg::*;
#(
   parameter int XLEN  = RF_XLEN,
   parameter int AW    = RF_AW,
   parameter int N_REQ = RF_WB_NREQ
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [N_REQ*AW-1:0]  req_rd,
   input  logic [N_REQ*XLEN-1:0] req_wd,
   output logic [N_REQ-1:0]     req_ready,
   input  logic                 iss_valid,
   input  logic [AW-1:0]        iss_rd,
   input  logic                 flush,
   input  logic [AW-1:0]        chk_rs1,
   input  logic [AW-1:0]        chk_rs2,
   output logic                 stall,
   output logic                 rf_we,
   output logic [AW-1:0]        rf_rd,
   output logic [XLEN-1:0]      rf_wd
`ifdef RF_WB_BYPASS_EN
   ,
   output logic                 byp1_valid,
   output logic [XLEN-1:0]      byp1_data,
   output logic                 byp2_valid,
   output logic [XLEN-1:0]      byp2_data
`endif
);

   localparam int NREG = 2 ** AW;

   logic [N_REQ-1:0] grant_s;
   logic             sel_any_s;
   logic [AW-1:0]    sel_rd_s;
   logic [XLEN-1:0]  sel_wd_s;
   logic [NREG-1:0]  pending_r;
   logic [NREG-1:0]  pending_nxt_s;
   logic             hz1_pend_s;
   logic             hz2_pend_s;
   logic             hz1_pipe_s;
   logic             hz2_pipe_s;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (req_valid),
      .grant (grant_s)
   );

   assign req_ready = grant_s;

   // One-hot grant mux: OR together the masked slices of the granted requester
   always_comb begin
      sel_any_s = |grant_s;
      sel_rd_s  = {AW{1'b0}};
      sel_wd_s  = {XLEN{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         sel_rd_s = sel_rd_s | (req_rd[i*AW +: AW] & {AW{grant_s[i]}});
         sel_wd_s = sel_wd_s | (req_wd[i*XLEN +: XLEN] & {XLEN{grant_s[i]}});
      end
   end

   // Write pipe: a granted non-x0 result becomes a reg_file write next cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we <= 1'b0;
         rf_rd <= {AW{1'b0}};
         rf_wd <= {XLEN{1'b0}};
      end else if (sel_any_s && (sel_rd_s != {AW{1'b0}})) begin
         rf_we <= 1'b1;
         rf_rd <= sel_rd_s;
         rf_wd <= sel_wd_s;
      end else begin
         rf_we <= 1'b0;
         rf_rd <= rf_rd;
         rf_wd <= rf_wd;
      end
   end

   // Scoreboard next state: flush, then clear at grant, then set on issue (set wins)
   always_comb begin
      if (flush) begin
         pending_nxt_s = {NREG{1'b0}};
      end else begin
         pending_nxt_s = pending_r;
      end
      if (sel_any_s) begin
         pending_nxt_s[sel_rd_s] = 1'b0;
      end else begin
         pending_nxt_s = pending_nxt_s;
      end
      if (iss_valid && (iss_rd != {AW{1'b0}})) begin
         pending_nxt_s[iss_rd] = 1'b1;
      end else begin
         pending_nxt_s = pending_nxt_s;
      end
      pending_nxt_s[0] = 1'b0;
   end

   // Scoreboard register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_r <= {NREG{1'b0}};
      end else begin
         pending_r <= pending_nxt_s;
      end
   end

   // Hazard terms: pending multi-cycle dest, and the write currently in the pipe
   always_comb begin
      hz1_pend_s = (chk_rs1 != {AW{1'b0}}) & pending_r[chk_rs1];
      hz2_pend_s = (chk_rs2 != {AW{1'b0}}) & pending_r[chk_rs2];
      hz1_pipe_s = (chk_rs1 != {AW{1'b0}}) & rf_we & (rf_rd == chk_rs1);
      hz2_pipe_s = (chk_rs2 != {AW{1'b0}}) & rf_we & (rf_rd == chk_rs2);
   end

`ifdef RF_WB_BYPASS_EN
   // Forwarding covers the write-before-read gap, so stall only on pending ops
   always_comb begin
      stall      = ~rst & (hz1_pend_s | hz2_pend_s);
      byp1_valid = hz1_pipe_s;
      byp1_data  = rf_wd;
      byp2_valid = hz2_pipe_s;
      byp2_data  = rf_wd;
   end
`else
   // Without forwarding, a write still in the pipe must also stall the reader
   always_comb begin
      stall = ~rst & (hz1_pend_s | hz2_pend_s | hz1_pipe_s | hz2_pipe_s);
   end
`endif

endmodule

// File: tb/tb_rf_wb_sched.sv
// Self-checking bench for rf_wb_sched: a queue/array-level model of the
// scheduler checked every negedge, plus directed scenarios with literal
// expectations. Builds with or without RF_WB_BYPASS_EN.
module tb_rf_wb_sched;
   import rf_wb_sched_pkg::*;

   localparam int XL  = RF_XLEN;
   localparam int AWB = RF_AW;
   localparam int N   = RF_WB_NREQ;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [N-1:0]       req_valid = '0;
   logic [N*AWB-1:0]   req_rd = '0;
   logic [N*XL-1:0]    req_wd = '0;
   logic [N-1:0]       req_ready;
   logic               iss_valid = 1'b0;
   logic [AWB-1:0]     iss_rd = '0;
   logic               flush = 1'b0;
   logic [AWB-1:0]     chk_rs1 = '0;
   logic [AWB-1:0]     chk_rs2 = '0;
   logic               stall;
   logic               rf_we;
   logic [AWB-1:0]     rf_rd;
   logic [XL-1:0]      rf_wd;
`ifdef RF_WB_BYPASS_EN
   logic               byp1_valid;
   logic [XL-1:0]      byp1_data;
   logic               byp2_valid;
   logic [XL-1:0]      byp2_data;
`endif

   rf_wb_sched #(.XLEN(XL), .AW(AWB), .N_REQ(N)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_rd(req_rd), .req_wd(req_wd), .req_ready(req_ready),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
      .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .stall(stall),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd)
`ifdef RF_WB_BYPASS_EN
      , .byp1_valid(byp1_valid), .byp1_data(byp1_data)
      , .byp2_valid(byp2_valid), .byp2_data(byp2_data)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit             pend_m [0:(1<<AWB)-1];
   int             ptr_m = 0;
   bit             we_m  = 1'b0;
   logic [AWB-1:0] rd_m  = '0;
   logic [XL-1:0]  wd_m  = '0;

   // Winner: first valid requester scanning ptr, ptr+1, ... with wrap; -1 if none
   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic bit hz(input logic [AWB-1:0] r);
      bit h;
      h = pend_m[r];
`ifndef RF_WB_BYPASS_EN
      h = h | (we_m && (rd_m == r));
`endif
      return (r != 0) && h;
   endfunction

   always begin
      @(posedge clk or posedge rst);
      if (rst) begin
         for (int i = 0; i < (1 << AWB); i++) pend_m[i] = 1'b0;
         ptr_m = 0; we_m = 1'b0; rd_m = '0; wd_m = '0;
      end else begin
         int g;
         logic [AWB-1:0] r;
         g = pick(req_valid, ptr_m);
         we_m = 1'b0;
         if (flush) for (int i = 0; i < (1 << AWB); i++) pend_m[i] = 1'b0;
         if (g >= 0) begin
            ptr_m = (g + 1) % N;
            r = req_rd[g*AWB +: AWB];
            pend_m[r] = 1'b0;
            if (r != 0) begin
               we_m = 1'b1;
               rd_m = r;
               wd_m = req_wd[g*XL +: XL];
            end
         end
         if (iss_valid && iss_rd != 0) pend_m[iss_rd] = 1'b1;
      end
   end

   // Compare process: every negedge, DUT outputs against the model
   always @(negedge clk) begin
      logic [N-1:0] exp_g;
      int g;
      exp_g = '0;
      g = pick(req_valid, ptr_m);
      if (!rst && g >= 0) exp_g[g] = 1'b1;
      check("m_ready", req_ready, exp_g);
      check("m_stall", stall, (!rst && (hz(chk_rs1) || hz(chk_rs2))));
      check("m_rf_we", rf_we, we_m);
      if (we_m) begin
         check("m_rf_rd", rf_rd, rd_m);
         check("m_rf_wd", rf_wd, wd_m);
      end
`ifdef RF_WB_BYPASS_EN
      check("m_byp1_v", byp1_valid, (chk_rs1 != 0) && we_m && (rd_m == chk_rs1));
      check("m_byp2_v", byp2_valid, (chk_rs2 != 0) && we_m && (rd_m == chk_rs2));
      if (we_m) check("m_byp1_d", byp1_data, wd_m);
`endif
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed stimulus ----------------
   logic [N-1:0]   exp_g2 [6];
   logic [AWB-1:0] exp_r2 [6];

   initial begin
      exp_g2 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      exp_r2 = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};

      // Reset state
      #12;
      req_valid = 3'b111;
      chk_rs1 = 5'd3;
      #1;
      check("rst_rf_we", rf_we, 1'b0);
      check("rst_rf_rd", rf_rd, 5'd0);
      check("rst_rf_wd", rf_wd, 32'd0);
      check("rst_ready", req_ready, 3'b000);
      check("rst_stall", stall, 1'b0);
      req_valid = '0;
      chk_rs1 = '0;
      @(posedge clk); #1;
      rst = 1'b0;

      // All three valid for six cycles: rotating grants, rf_rd one cycle later
      req_rd = {5'd3, 5'd2, 5'd1};
      req_wd = {32'h0000_00C3, 32'h0000_00B2, 32'h0000_00A1};
      req_valid = 3'b111;
      for (int j = 0; j < 6; j++) begin
         #2;
         check("rr_grant", req_ready, exp_g2[j]);
         if (j > 0) check("rr_rf_rd", rf_rd, exp_r2[j-1]);
         tick();
      end
      req_valid = '0;
      #2;
      check("rr_last_we", rf_we, 1'b1);
      check("rr_last_rd", rf_rd, 5'd3);
      check("rr_last_wd", rf_wd, 32'h0000_00C3);

      // RAW on a pending MDU destination
      tick();
      iss_valid = 1'b1; iss_rd = 5'd5;
      tick();
      iss_valid = 1'b0; chk_rs1 = 5'd5;
      #2; check("raw_stall_a", stall, 1'b1);
      tick();
      #2; check("raw_stall_b", stall, 1'b1);
      req_rd = {5'd5, 5'd0, 5'd0};
      req_wd = {32'h5555_0005, 32'd0, 32'd0};
      req_valid = 3'b100;
      #1;
      check("raw_mdu_grant", req_ready, 3'b100);
      check("raw_stall_at_grant", stall, 1'b1);
      tick();
      req_valid = '0;
      #2;
      check("raw_pipe_we", rf_we, 1'b1);
      check("raw_pipe_rd", rf_rd, 5'd5);
`ifdef RF_WB_BYPASS_EN
      check("raw_byp_stall", stall, 1'b0);
      check("raw_byp1_valid", byp1_valid, 1'b1);
      check("raw_byp1_data", byp1_data, 32'h5555_0005);
`else
      check("raw_pipe_stall", stall, 1'b1);
`endif
      tick();
      #2; check("raw_clear", stall, 1'b0);

      // Issue and grant of rd 7 in the same cycle: set wins
      chk_rs1 = 5'd0;
      iss_valid = 1'b1; iss_rd = 5'd7;
      req_rd = {5'd0, 5'd7, 5'd0};
      req_wd = {32'd0, 32'h0000_0077, 32'd0};
      req_valid = 3'b010;
      #2; check("sw_lsu_grant", req_ready, 3'b010);
      tick();
      iss_valid = 1'b0; req_valid = '0; chk_rs2 = 5'd7;
      #2; check("sw_stall_a", stall, 1'b1);
      tick();
      #2; check("sw_stall_b", stall, 1'b1);

      // x0 destination: accepted but never written, never pending
      chk_rs2 = 5'd0;
      req_rd = '0;
      req_wd = {32'd0, 32'd0, 32'hDEAD_BEEF};
      req_valid = 3'b001;
      #2; check("x0_ready", req_ready, 3'b001);
      tick();
      req_valid = '0;
      #2; check("x0_no_we", rf_we, 1'b0);
      iss_valid = 1'b1; iss_rd = 5'd0;
      tick();
      iss_valid = 1'b0; chk_rs1 = 5'd0;
      #2; check("x0_no_stall", stall, 1'b0);

      // Flush clears everything except the same-cycle issue
      tick();
      iss_valid = 1'b1; iss_rd = 5'd3;  tick();
      iss_rd = 5'd9;  tick();
      iss_rd = 5'd12; tick();
      iss_valid = 1'b0; chk_rs1 = 5'd9;
      #2; check("fl_pre_stall", stall, 1'b1);
      flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd4;
      tick();
      flush = 1'b0; iss_valid = 1'b0;
      chk_rs1 = 5'd3; chk_rs2 = 5'd9;
      #2; check("fl_3_9", stall, 1'b0);
      chk_rs1 = 5'd12; chk_rs2 = 5'd7;
      #1; check("fl_12_7", stall, 1'b0);
      chk_rs1 = 5'd4; chk_rs2 = 5'd0;
      #1; check("fl_4_kept", stall, 1'b1);
      tick();

      // Mid-cycle reset with a write in flight
      chk_rs1 = 5'd0;
      req_rd = {5'd0, 5'd0, 5'd10};
      req_wd = {32'd0, 32'd0, 32'h0000_1010};
      req_valid = 3'b001;
      iss_valid = 1'b1; iss_rd = 5'd11;
      tick();
      req_valid = '0; iss_valid = 1'b0; chk_rs1 = 5'd11;
      #1;
      check("mr_we_before", rf_we, 1'b1);
      check("mr_stall_before", stall, 1'b1);
      rst = 1'b1;
      #1;
      check("mr_we_dropped", rf_we, 1'b0);
      check("mr_stall_cleared", stall, 1'b0);
      #1;
      rst = 1'b0;
      req_rd = {5'd0, 5'd13, 5'd12};
      req_wd = {32'd0, 32'h0000_0D0D, 32'h0000_0C0C};
      req_valid = 3'b011;
      tick();
      req_valid = '0;
      #2;
      check("mr_ptr_restart_we", rf_we, 1'b1);
      check("mr_ptr_restart_rd", rf_rd, 5'd12);
      check("mr_pending_lost", stall, 1'b0);
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
